// File: rtl/alu_pkg.sv
// Shared definitions for the RV32 integer ALU: opcode encoding and default width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_PASSB = 4'b1010,
    ALU_PASSA = 4'b1011,
    ALU_SEQ   = 4'b1100,
    ALU_SNE   = 4'b1101,
    ALU_SGE   = 4'b1110,
    ALU_SGEU  = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational log2 barrel shifter for SLL/SRL/SRA.
// Left shifts reuse the right-shift stages by bit-reversing data in and out.
module alu_shifter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]         i_data,
  input  logic [$clog2(WIDTH)-1:0] i_shamt,
  input  logic                     i_dir,    // 0: left, 1: right
  input  logic                     i_arith,  // sign-fill on right shift
  output logic [WIDTH-1:0]         o_data
);

  localparam int unsigned SH = $clog2(WIDTH);

  logic [WIDTH-1:0] w_rev_in;
  logic [WIDTH-1:0] w_rev_out;
  logic [WIDTH-1:0] w_in;
  logic             w_fill;
  logic [WIDTH-1:0] w_stage [SH+1];

  // Bit-reverse the input so a left shift becomes a right shift.
  always_comb begin
    w_rev_in = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_rev_in[i] = i_data[WIDTH-1-i];
    end
  end

  assign w_in       = i_dir ? i_data : w_rev_in;
  assign w_fill     = i_dir & i_arith & i_data[WIDTH-1];
  assign w_stage[0] = w_in;

  genvar k;
  for (k = 0; k < SH; k++) begin : g_stage
    localparam int unsigned STEP = 1 << k;
    assign w_stage[k+1] = i_shamt[k] ? {{STEP{w_fill}}, w_stage[k][WIDTH-1:STEP]}
                                     : w_stage[k];
  end

  // Undo the reversal for left shifts.
  always_comb begin
    w_rev_out = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_rev_out[i] = w_stage[SH][WIDTH-1-i];
    end
  end

  assign o_data = i_dir ? w_stage[SH] : w_rev_out;

endmodule

// File: rtl/alu.sv
// RV32 integer ALU: 16 operations, registered result, one-cycle latency.
// Optional registered status flags when ALU_FLAGS_EN is defined.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       alu_select,
  output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf
`endif
);

  localparam int unsigned SH = $clog2(WIDTH);

  alu_op_e          w_op;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_slt;
  logic             w_sltu;
  logic             w_eq;
  logic [WIDTH-1:0] w_shift;
  logic             w_shift_dir;
  logic             w_shift_arith;
  logic [WIDTH-1:0] w_next;

  assign w_op = alu_op_e'(alu_select);

  // Single adder: every op other than ADD uses it as a subtractor (a + ~b + 1),
  // so the comparisons fall out of the same carry and overflow terms.
  assign w_sub   = (w_op != ALU_ADD);
  assign w_b_eff = w_sub ? ~in_b : in_b;
  assign {w_cout, w_sum} = {1'b0, in_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
  assign w_ovf   = (in_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
  assign w_slt   = w_sum[WIDTH-1] ^ w_ovf;
  assign w_sltu  = ~w_cout;
  assign w_eq    = (in_a == in_b);

  assign w_shift_dir   = (w_op == ALU_SRL) || (w_op == ALU_SRA);
  assign w_shift_arith = (w_op == ALU_SRA);

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .i_data  (in_a),
    .i_shamt (in_b[SH-1:0]),
    .i_dir   (w_shift_dir),
    .i_arith (w_shift_arith),
    .o_data  (w_shift)
  );

  // Opcode mux selecting the next registered result.
  always_comb begin
    w_next = '0;
    case (w_op)
      ALU_ADD,
      ALU_SUB:   w_next = w_sum;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:   w_next = w_shift;
      ALU_SLT:   w_next = {{(WIDTH-1){1'b0}}, w_slt};
      ALU_SLTU:  w_next = {{(WIDTH-1){1'b0}}, w_sltu};
      ALU_XOR:   w_next = in_a ^ in_b;
      ALU_OR:    w_next = in_a | in_b;
      ALU_AND:   w_next = in_a & in_b;
      ALU_PASSB: w_next = in_b;
      ALU_PASSA: w_next = in_a;
      ALU_SEQ:   w_next = {{(WIDTH-1){1'b0}}, w_eq};
      ALU_SNE:   w_next = {{(WIDTH-1){1'b0}}, ~w_eq};
      ALU_SGE:   w_next = {{(WIDTH-1){1'b0}}, ~w_slt};
      ALU_SGEU:  w_next = {{(WIDTH-1){1'b0}}, ~w_sltu};
      default:   w_next = '0;
    endcase
  end

  // Result register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else begin
      result <= w_next;
    end
  end

`ifdef ALU_FLAGS_EN
  logic w_is_addsub;

  assign w_is_addsub = (w_op == ALU_ADD) || (w_op == ALU_SUB);

  // Status flags registered alongside the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_zero  <= 1'b0;
      flag_neg   <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
    end else begin
      flag_zero  <= (w_next == '0);
      flag_neg   <= w_next[WIDTH-1];
      flag_carry <= w_is_addsub & w_cout;
      flag_ovf   <= w_is_addsub & w_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (WIDTH=32); flag checks when ALU_FLAGS_EN is defined.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  alu_select;
  logic [31:0] result;
`ifdef ALU_FLAGS_EN
  logic flag_zero, flag_neg, flag_carry, flag_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] sb_res[$];
  string       sb_nm[$];

  alu #(
    .WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_select (alu_select),
    .result     (result)
`ifdef ALU_FLAGS_EN
    ,
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model, written from the opcode table.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return {31'd0, $signed(a) < $signed(b)};
      4'd4:  return {31'd0, a < b};
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return $signed(a) >>> sh;
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      4'd11: return a;
      4'd12: return {31'd0, a == b};
      4'd13: return {31'd0, a != b};
      4'd14: return {31'd0, $signed(a) >= $signed(b)};
      default: return {31'd0, a >= b};
    endcase
  endfunction

  // Drive one operation at the falling edge and record its expected result.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string nm);
    @(negedge clk);
    in_a       = a;
    in_b       = b;
    alu_select = op;
    sb_res.push_back(exp);
    sb_nm.push_back(nm);
  endtask

  task automatic test_reset;
    logic [31:0] exp;
    string nm;
    n_tests++;
    if (result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_initial: result=%h expected=%h", result, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(ALU_ADD, 32'd3, 32'd4, 32'd7, "reset_add_3_4");
    @(posedge clk); #1;
    n_tests++;
    if (sb_res.size() == 0) begin
      n_fail++;
      $display("FAIL reset_add_3_4: scoreboard empty");
    end else begin
      exp = sb_res.pop_front(); nm = sb_nm.pop_front();
      if (result !== exp) begin
        n_fail++;
        $display("FAIL %s: result=%h expected=%h", nm, result, exp);
      end
    end
    // Assert reset mid-cycle: result must clear with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: result=%h expected=%h", result, 32'h0);
    end
    @(posedge clk); #1;
    n_tests++;
    if (result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_held: result=%h expected=%h", result, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(ALU_ADD, 32'd3, 32'd4, 32'd7, "reset_release_add");
    @(posedge clk); #1;
    n_tests++;
    if (sb_res.size() == 0) begin
      n_fail++;
      $display("FAIL reset_release_add: scoreboard empty");
    end else begin
      exp = sb_res.pop_front(); nm = sb_nm.pop_front();
      if (result !== exp) begin
        n_fail++;
        $display("FAIL %s: result=%h expected=%h", nm, result, exp);
      end
    end
  endtask

  task automatic test_arith;
    logic [3:0]  ops [3] = '{ALU_ADD, ALU_SUB, ALU_SUB};
    logic [31:0] va  [3] = '{32'hFFFFFFFF, 32'h0, 32'h10};
    logic [31:0] vb  [3] = '{32'h1, 32'h1, 32'h3};
    logic [31:0] ve  [3] = '{32'h0, 32'hFFFFFFFF, 32'h0000000D};
    logic [31:0] exp;
    string nm;
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], va[i], vb[i], ve[i], $sformatf("arith_%0d", i));
      @(posedge clk); #1;
      n_tests++;
      if (sb_res.size() == 0) begin
        n_fail++;
        $display("FAIL arith_%0d: scoreboard empty", i);
      end else begin
        exp = sb_res.pop_front(); nm = sb_nm.pop_front();
        if (result !== exp) begin
          n_fail++;
          $display("FAIL %s: result=%h expected=%h", nm, result, exp);
        end
      end
    end
  endtask

  task automatic test_compare;
    logic [3:0]  ops [8] = '{ALU_SLT, ALU_SLTU, ALU_SGE, ALU_SGEU, ALU_SEQ, ALU_SNE, ALU_SLT, ALU_SGE};
    logic [31:0] va  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h5A, 32'h5A, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] vb  [8] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h5A, 32'h5A, 32'h7FFFFFFF, 32'h80000000};
    logic [31:0] ve  [8] = '{32'h1, 32'h0, 32'h0, 32'h1, 32'h1, 32'h0, 32'h1, 32'h1};
    logic [31:0] exp;
    string nm;
    for (int i = 0; i < 8; i++) begin
      drive(ops[i], va[i], vb[i], ve[i], $sformatf("compare_%0d", i));
      @(posedge clk); #1;
      n_tests++;
      if (sb_res.size() == 0) begin
        n_fail++;
        $display("FAIL compare_%0d: scoreboard empty", i);
      end else begin
        exp = sb_res.pop_front(); nm = sb_nm.pop_front();
        if (result !== exp) begin
          n_fail++;
          $display("FAIL %s: result=%h expected=%h", nm, result, exp);
        end
      end
    end
  endtask

  task automatic test_shift;
    logic [3:0]  ops [6] = '{ALU_SLL, ALU_SRL, ALU_SRA, ALU_SRA, ALU_SLL, ALU_SRA};
    logic [31:0] vb  [6] = '{32'h4, 32'h4, 32'h4, 32'h24, 32'h0, 32'h0};
    logic [31:0] ve  [6] = '{32'h00000010, 32'h08000000, 32'hF8000000, 32'hF8000000,
                             32'h80000001, 32'h80000001};
    logic [31:0] exp;
    string nm;
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], 32'h80000001, vb[i], ve[i], $sformatf("shift_%0d", i));
      @(posedge clk); #1;
      n_tests++;
      if (sb_res.size() == 0) begin
        n_fail++;
        $display("FAIL shift_%0d: scoreboard empty", i);
      end else begin
        exp = sb_res.pop_front(); nm = sb_nm.pop_front();
        if (result !== exp) begin
          n_fail++;
          $display("FAIL %s: result=%h expected=%h", nm, result, exp);
        end
      end
    end
  endtask

  task automatic test_logic;
    logic [3:0]  ops [5] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_PASSB, ALU_PASSA};
    logic [31:0] ve  [5] = '{32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0};
    logic [31:0] exp;
    string nm;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], 32'hF0F0F0F0, 32'h0FF00FF0, ve[i], $sformatf("logic_%0d", i));
      @(posedge clk); #1;
      n_tests++;
      if (sb_res.size() == 0) begin
        n_fail++;
        $display("FAIL logic_%0d: scoreboard empty", i);
      end else begin
        exp = sb_res.pop_front(); nm = sb_nm.pop_front();
        if (result !== exp) begin
          n_fail++;
          $display("FAIL %s: result=%h expected=%h", nm, result, exp);
        end
      end
    end
  endtask

  // Random ops on consecutive edges; each result must appear one edge after
  // its inputs and hold until the following edge.
  task automatic test_back_to_back;
    logic [3:0]  op;
    logic [31:0] a, b, exp, prev;
    string nm;
    prev = result;
    for (int i = 0; i < 64; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      if (i % 8 == 1) a = 32'h80000000;
      drive(op, a, b, model(op, a, b), $sformatf("b2b_%0d_op%0d", i, op));
      n_tests++;
      if (result !== prev) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d: result=%h expected=%h", i, result, prev);
      end
      @(posedge clk); #1;
      n_tests++;
      if (sb_res.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_%0d: scoreboard empty", i);
      end else begin
        exp = sb_res.pop_front(); nm = sb_nm.pop_front();
        if (result !== exp) begin
          n_fail++;
          $display("FAIL %s: a=%h b=%h result=%h expected=%h", nm, a, b, result, exp);
        end
        prev = exp;
      end
    end
  endtask

`ifdef ALU_FLAGS_EN
  task automatic test_flags;
    logic [3:0]  ops [4] = '{ALU_ADD, ALU_SUB, ALU_ADD, ALU_XOR};
    logic [31:0] va  [4] = '{32'h7FFFFFFF, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb  [4] = '{32'h1, 32'h5, 32'h1, 32'h1};
    logic [31:0] ve  [4] = '{32'h80000000, 32'h0, 32'h0, 32'hFFFFFFFE};
    // {zero, neg, carry, ovf}
    logic [3:0]  vf  [4] = '{4'b0101, 4'b1010, 4'b1010, 4'b0100};
    logic [31:0] exp;
    logic [3:0]  fl;
    string nm;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], va[i], vb[i], ve[i], $sformatf("flags_%0d", i));
      @(posedge clk); #1;
      n_tests++;
      if (sb_res.size() == 0) begin
        n_fail++;
        $display("FAIL flags_%0d: scoreboard empty", i);
      end else begin
        exp = sb_res.pop_front(); nm = sb_nm.pop_front();
        if (result !== exp) begin
          n_fail++;
          $display("FAIL %s: result=%h expected=%h", nm, result, exp);
        end
      end
      fl = {flag_zero, flag_neg, flag_carry, flag_ovf};
      n_tests++;
      if (fl !== vf[i]) begin
        n_fail++;
        $display("FAIL flags_%0d_zncv: got=%b expected=%b", i, fl, vf[i]);
      end
    end
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    in_a       = '0;
    in_b       = '0;
    alu_select = '0;
    #12;
    test_reset();
    test_arith();
    test_compare();
    test_shift();
    test_logic();
    test_back_to_back();
`ifdef ALU_FLAGS_EN
    test_flags();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
